// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and clog2 helper shared by spi_slave and spi_master
package spi_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizers for sclk/cs_n/mosi plus sclk edge detect from a third stage
//   clk, rst_n            system clock, async active-low reset
//   sclk, cs_n, mosi      raw SPI bus inputs
//   cs_n_s, mosi_s        synchronized cs_n and mosi
//   sclk_rise, sclk_fall  one-clk pulses on synchronized sclk edges
module spi_sync_edge #(
  parameter int CPOL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);
  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= CPOL != 0 ? 3'b111 : 3'b000;
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  assign cs_n_s    = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave with tx holding register and rx valid/ready handshake
//   clk, rst_n                 system clock, async active-low reset
//   sclk, cs_n, mosi, miso     SPI bus; miso_oe high while synchronized cs_n is low
//   tx_data/tx_valid/tx_ready  fills the tx holding register
//   rx_data/rx_valid/rx_ready  last received word, held until accepted
//   rx_overrun, tx_underrun    1-clk error pulses, present only with SPI_SLAVE_ERR_FLAGS_EN
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  ,
  output logic                  rx_overrun,
  output logic                  tx_underrun
`endif
);
  localparam int CW = clog2(DATA_WIDTH + 1);
  logic                  cs_s, mosi_s, rise, fall, lead, trail;
  logic                  smp, shf, ld, hs, last, done, hold_full, bit_q;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, hold;
  spi_sync_edge #(.CPOL(CPOL)) u_sync (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .cs_n_s(cs_s), .mosi_s(mosi_s), .sclk_rise(rise), .sclk_fall(fall)
  );
  assign lead  = CPOL != 0 ? fall : rise;
  assign trail = CPOL != 0 ? rise : fall;
  assign smp   = state == ST_SHIFT && (CPHA != 0 ? trail : lead);
  // CPHA=0: a trailing edge with no sample yet in this word is the tail of the previous word
  assign shf   = state == ST_SHIFT && (CPHA != 0 ? lead : trail && cnt != '0);
  assign ld    = !cs_s && (state == ST_LOAD || state == ST_DONE);
  assign done  = state == ST_DONE;
  assign last  = smp && cnt == CW'(DATA_WIDTH - 1);
  assign hs    = tx_valid && tx_ready;
  assign tx_ready = !hold_full;
  assign miso_oe  = !cs_s;
  assign miso     = miso_oe && (CPHA != 0 ? bit_q : tx_sr[DATA_WIDTH-1]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= cs_s ? ST_IDLE :
                  state == ST_IDLE ? ST_LOAD :
                  state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_SHIFT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_q     <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      if (cs_s) begin
        cnt   <= '0;
        tx_sr <= '0;
        rx_sr <= '0;
        bit_q <= 1'b0;
      end else begin
        if (ld) begin
          tx_sr <= hold_full ? hold : '0;
          cnt   <= '0;
        end else if (shf) begin
          bit_q <= tx_sr[DATA_WIDTH-1];
          tx_sr <= tx_sr << 1;
        end
        if (smp) begin
          rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
          cnt   <= cnt + 1'b1;
        end
      end
      if (ld && hold_full) hold_full <= 1'b0;
      else if (hs) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      if (done && !rx_valid) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overrun  <= done && rx_valid;
      tx_underrun <= ld && !hold_full;
    end
`endif
endmodule
